// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM soft-start/soft-stop controller.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {StOff, StUp, StDown, StHold} state_e;

    // Ramp rate codes: one step every 1/2/4/8 PWM periods
    localparam logic [1:0] RateDiv1 = 2'd0;
    localparam logic [1:0] RateDiv2 = 2'd1;
    localparam logic [1:0] RateDiv4 = 2'd2;
    localparam logic [1:0] RateDiv8 = 2'd3;

    localparam int unsigned MaxDutyW = 32;

    // Divider count on which a step fires (2^rate - 1)
    function automatic logic [2:0] rate_last(input logic [1:0] rate);
        case (rate)
            RateDiv1: return 3'd0;
            RateDiv2: return 3'd1;
            RateDiv4: return 3'd3;
            RateDiv8: return 3'd7;
        endcase
    endfunction

    // Replicate the 3-bit code MSB-first into the top w bits, result LSB-aligned
    function automatic logic [MaxDutyW-1:0] speed_to_duty(input logic [2:0] s,
                                                          input int unsigned w);
        logic [MaxDutyW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxDutyW; i++) begin
            if (i < w) begin
                r[5'(w - 1 - i)] = s[2'(2 - (i % 3))];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic-width two-flop synchronizer with asynchronous active-low reset.
module sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop controller: slews the PWM duty toward a pad-selected target,
// one step per (divided) PWM period boundary.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned STEP   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [2:0]        speed,
    input  logic [1:0]        rate,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty_out,
    output logic              pwm_en,
    output logic              busy,
    output logic              at_target
);

    localparam int unsigned       ExtW       = DUTY_W + 1;
    localparam logic [DUTY_W:0]   StepExt    = ExtW'(STEP);
    localparam logic [DUTY_W-1:0] StepNarrow = DUTY_W'(STEP);

    logic              enable_sync;
    logic [2:0]        speed_sync;
    logic [DUTY_W-1:0] tgt_d, tgt_q;
    logic [DUTY_W-1:0] duty_d, duty_q;
    logic [2:0]        cnt_d, cnt_q;
    state_e            state_d, state_q;
    logic              pwm_en_q, busy_q, at_target_q;
    logic              step_due;
    logic [DUTY_W:0]   up_sum, tgt_ext, dn_thresh;

    sync2 #(.Width(1)) u_sync_enable (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (enable),
        .q     (enable_sync)
    );

    sync2 #(.Width(3)) u_sync_speed (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (speed),
        .q     (speed_sync)
    );

    always_comb begin
        tgt_d     = enable_sync ? DUTY_W'(speed_to_duty(speed_sync, DUTY_W)) : '0;
        up_sum    = {1'b0, duty_q} + StepExt;
        tgt_ext   = {1'b0, tgt_q};
        dn_thresh = tgt_ext + StepExt;
        step_due  = period_end && (cnt_q == rate_last(rate));

        // Direction comes from the live comparison, so a fresh target is honoured at once
        duty_d = duty_q;
        if (step_due) begin
            if (duty_q < tgt_q) begin
                duty_d = (up_sum > tgt_ext) ? tgt_q : up_sum[DUTY_W-1:0];
            end else if (duty_q > tgt_q) begin
                duty_d = ({1'b0, duty_q} < dn_thresh) ? tgt_q : duty_q - StepNarrow;
            end
        end

        // Judged on the post-step duty so HOLD/OFF land on the same edge as the final step
        if (duty_d < tgt_q) begin
            state_d = StUp;
        end else if (duty_d > tgt_q) begin
            state_d = StDown;
        end else if (tgt_q != '0) begin
            state_d = StHold;
        end else begin
            state_d = StOff;
        end

        cnt_d = cnt_q;
        if (state_d != state_q || state_d == StHold || state_d == StOff) begin
            cnt_d = '0;
        end else if (step_due) begin
            cnt_d = '0;
        end else if (period_end) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StOff;
            duty_q      <= '0;
            tgt_q       <= '0;
            cnt_q       <= '0;
            pwm_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            pwm_en_q    <= (state_d != StOff);
            busy_q      <= (state_d == StUp) || (state_d == StDown);
            at_target_q <= (state_d == StHold) || (state_d == StOff);
        end
    end

    assign duty_out  = duty_q;
    assign pwm_en    = pwm_en_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;

endmodule
